// File: rtl/spi_mosi_rx.sv
// SPI slave MOSI receiver: LSB-first word assembly on spi_clk while spi_cs is low,
// feeding a first-word-fall-through FIFO with sticky overrun and frame-abort flags.
module spi_mosi_rx #(
    parameter int DSIZE  = 8,
    parameter int FDEPTH = 4
) (
    input  logic                     spi_clk,
    input  logic                     spi_rst_n,
    input  logic                     spi_cs,
    input  logic                     spi_mosi_in,
    input  logic                     read_req,
    input  logic                     ovr_clr,
    output logic [DSIZE-1:0]         data_out,
    output logic                     data_av,
    output logic [$clog2(FDEPTH):0]  fill,
    output logic                     overrun,
    output logic                     frame_err
);

    // state | meaning
    // IDLE  | chip-select high, no word in progress, bitcnt held at 0
    // SHIFT | chip-select low, sampling one bit per edge into shreg

    localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam int PW = $clog2(FDEPTH);
    localparam int FW = PW + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);
    localparam logic [FW-1:0] FULL_CNT = FW'(FDEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic [DSIZE-1:0]   shreg_q, shreg_d;
    logic               push, ferr_d;

    logic [DSIZE-1:0]   mem [FDEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [FW-1:0]      fill_q;
    logic               pop, full, wr_en, drop;

    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // The edge that first sees chip-select low already captures bit 0.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_d   = 1'b0;
        if (!spi_cs) begin
            state_d           = SHIFT;
            shreg_d[bitcnt_q] = spi_mosi_in;
            if (bitcnt_q == LAST_BIT) begin
                push     = 1'b1;
                bitcnt_d = '0;
            end else begin
                bitcnt_d = bitcnt_q + BW'(1);
            end
        end else begin
            state_d  = IDLE;
            bitcnt_d = '0;
            shreg_d  = '0;
            ferr_d   = (state_q == SHIFT) && (bitcnt_q != '0);
        end
    end

    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            frame_err <= ferr_d;
        end
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    assign pop   = read_req && (fill_q != '0);
    assign full  = (fill_q == FULL_CNT);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            for (int i = 0; i < FDEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wptr_q] <= shreg_d;
        end
    end

    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + PW'(1);
            if (pop)   rptr_q <= rptr_q + PW'(1);
            case ({wr_en, pop})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
            if (drop)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    assign data_out = mem[rptr_q];
    assign data_av  = (fill_q != '0);
    assign fill     = fill_q;

endmodule

// File: tb/tb_spi_mosi_rx.sv
// Bench for spi_mosi_rx: directed scenarios plus randomized frames checked
// against a queue-based reference model of the receiver and FIFO.
module tb_spi_mosi_rx;

    localparam int DSIZE  = 8;
    localparam int FDEPTH = 4;

    logic       spi_clk = 1'b0;
    logic       spi_rst_n = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_mosi_in = 1'b0;
    logic       read_req = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_av;
    logic [2:0] fill;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    spi_mosi_rx #(.DSIZE(DSIZE), .FDEPTH(FDEPTH)) dut (
        .spi_clk    (spi_clk),
        .spi_rst_n  (spi_rst_n),
        .spi_cs     (spi_cs),
        .spi_mosi_in(spi_mosi_in),
        .read_req   (read_req),
        .ovr_clr    (ovr_clr),
        .data_out   (data_out),
        .data_av    (data_av),
        .fill       (fill),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 spi_clk = ~spi_clk;

    // Reference model: partial word as value + bit count, FIFO as a queue.
    logic [7:0] m_q[$];
    int         m_nb;
    logic [7:0] m_part;
    logic       m_ovr;
    logic       m_ferr;

    task automatic model_reset();
        m_q.delete();
        m_nb   = 0;
        m_part = 8'h00;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic m, input logic r, input logic cl);
        logic       got_word;
        logic       dropped;
        logic       pop_ok;
        logic [7:0] w;
        got_word = 1'b0;
        dropped  = 1'b0;
        w        = 8'h00;
        pop_ok   = r && (m_q.size() > 0);
        m_ferr   = 1'b0;
        if (!c) begin
            m_part = m_part | (8'(m) << m_nb);
            m_nb++;
            if (m_nb == DSIZE) begin
                got_word = 1'b1;
                w        = m_part;
                m_part   = 8'h00;
                m_nb     = 0;
            end
        end else begin
            m_ferr = (m_nb != 0);
            m_nb   = 0;
            m_part = 8'h00;
        end
        if (pop_ok) void'(m_q.pop_front());
        if (got_word) begin
            if (m_q.size() < FDEPTH) m_q.push_back(w);
            else dropped = 1'b1;
        end
        if (dropped) m_ovr = 1'b1;
        else if (cl) m_ovr = 1'b0;
    endtask

    task automatic step(input logic c, input logic m, input logic r, input logic cl);
        spi_cs      = c;
        spi_mosi_in = m;
        read_req    = r;
        ovr_clr     = cl;
        @(posedge spi_clk);
        model_edge(c, m, r, cl);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rd_last);
        for (int i = 0; i < DSIZE; i++) step(1'b0, w[i], (i == DSIZE - 1) ? rd_last : 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        spi_rst_n = 1'b0;
        #3;
        n_checks++; if (data_out !== 8'h00) $display("FAIL rst_data_out: got %0h expected 0", data_out); else n_pass++;
        n_checks++; if (data_av !== 1'b0) $display("FAIL rst_data_av: got %0b expected 0", data_av); else n_pass++;
        n_checks++; if (fill !== 3'd0) $display("FAIL rst_fill: got %0d expected 0", fill); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %0b expected 0", overrun); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %0b expected 0", frame_err); else n_pass++;
        spi_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hA5;
        for (int i = 0; i < DSIZE; i++) begin
            step(1'b0, w[i], 1'b0, 1'b0);
            if (i == DSIZE - 2) begin
                n_checks++; if (data_av !== 1'b0) $display("FAIL single_early_av: got %0b expected 0", data_av); else n_pass++;
            end
        end
        n_checks++; if (data_out !== 8'hA5) $display("FAIL single_data: got %0h expected a5", data_out); else n_pass++;
        n_checks++; if (data_av !== 1'b1) $display("FAIL single_av: got %0b expected 1", data_av); else n_pass++;
        n_checks++; if (fill !== 3'd1) $display("FAIL single_fill: got %0d expected 1", fill); else n_pass++;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_av !== 1'b0) $display("FAIL single_pop_av: got %0b expected 0", data_av); else n_pass++;
        n_checks++; if (fill !== 3'd0) $display("FAIL single_pop_fill: got %0d expected 0", fill); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL single_ferr: got %0b expected 0", frame_err); else n_pass++;
    endtask

    task automatic test_overrun();
        for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
        n_checks++; if (fill !== 3'd4) $display("FAIL ovr_fill4: got %0d expected 4", fill); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %0b expected 0", overrun); else n_pass++;
        send_word(8'hFF, 1'b0);
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0b expected 1", overrun); else n_pass++;
        n_checks++; if (fill !== 3'd4) $display("FAIL ovr_fill_sat: got %0d expected 4", fill); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (frame_err !== 1'b0) $display("FAIL ovr_ferr: got %0b expected 0", frame_err); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (data_out !== 8'(k)) $display("FAIL ovr_order: got %0h expected %0h", data_out, k); else n_pass++;
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        n_checks++; if (data_av !== 1'b0) $display("FAIL ovr_drained: got %0b expected 0", data_av); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b expected 1", overrun); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %0b expected 0", overrun); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q[$];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'hFF};
        for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
        send_word(8'hFF, 1'b1);
        n_checks++; if (overrun !== 1'b0) $display("FAIL pp_overrun: got %0b expected 0", overrun); else n_pass++;
        n_checks++; if (fill !== 3'd4) $display("FAIL pp_fill: got %0d expected 4", fill); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        foreach (exp_q[k]) begin
            n_checks++; if (data_out !== exp_q[k]) $display("FAIL pp_order: got %0h expected %0h", data_out, exp_q[k]); else n_pass++;
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        n_checks++; if (fill !== 3'd0) $display("FAIL pp_empty: got %0d expected 0", fill); else n_pass++;
    endtask

    task automatic test_frame_err();
        logic [7:0] w;
        send_word(8'h5A, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        w = 8'h07;
        for (int i = 0; i < 3; i++) step(1'b0, w[i], 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (frame_err !== 1'b1) $display("FAIL ferr_pulse: got %0b expected 1", frame_err); else n_pass++;
        n_checks++; if (fill !== 3'd1) $display("FAIL ferr_fill: got %0d expected 1", fill); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (frame_err !== 1'b0) $display("FAIL ferr_one_cycle: got %0b expected 0", frame_err); else n_pass++;
        send_word(8'h3C, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (data_out !== 8'h3C) $display("FAIL ferr_next_word: got %0h expected 3c", data_out); else n_pass++;
        n_checks++; if (fill !== 3'd1) $display("FAIL ferr_next_fill: got %0d expected 1", fill); else n_pass++;
        step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_exact_frame();
        send_word(8'h96, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (frame_err !== 1'b0) $display("FAIL exact_ferr: got %0b expected 0", frame_err); else n_pass++;
        n_checks++; if (data_out !== 8'h96) $display("FAIL exact_data: got %0h expected 96", data_out); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            n_checks++; if (fill !== 3'd0) $display("FAIL empty_read_fill: got %0d expected 0", fill); else n_pass++;
            n_checks++; if (data_av !== 1'b0) $display("FAIL empty_read_av: got %0b expected 0", data_av); else n_pass++;
        end
        n_checks++; if (overrun !== 1'b0) $display("FAIL empty_read_ovr: got %0b expected 0", overrun); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        w = 8'h77;
        for (int i = 0; i < 5; i++) step(1'b0, w[i], 1'b0, 1'b0);
        n_checks++; if (fill !== 3'd2) $display("FAIL arst_pre_fill: got %0d expected 2", fill); else n_pass++;
        #2;
        spi_rst_n = 1'b0;
        #1;
        n_checks++; if (data_out !== 8'h00) $display("FAIL arst_data: got %0h expected 0", data_out); else n_pass++;
        n_checks++; if (data_av !== 1'b0) $display("FAIL arst_av: got %0b expected 0", data_av); else n_pass++;
        n_checks++; if (fill !== 3'd0) $display("FAIL arst_fill: got %0d expected 0", fill); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL arst_ferr: got %0b expected 0", frame_err); else n_pass++;
        spi_cs = 1'b1;
        #2;
        spi_rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h81, 1'b0);
        n_checks++; if (data_out !== 8'h81) $display("FAIL arst_next_data: got %0h expected 81", data_out); else n_pass++;
        n_checks++; if (fill !== 3'd1) $display("FAIL arst_next_fill: got %0d expected 1", fill); else n_pass++;
        step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] stim[$];
        int nbits;
        for (int f = 0; f < 40; f++) begin
            nbits = $urandom_range(0, 3) * DSIZE + (($urandom_range(0, 2) == 0) ? $urandom_range(1, DSIZE - 1) : 0);
            for (int b = 0; b < nbits; b++)
                stim.push_back({1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0)});
            for (int g = 0; g < $urandom_range(1, 3); g++)
                stim.push_back({1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)});
        end
        foreach (stim[k]) begin
            step(stim[k][3], stim[k][2], stim[k][1], stim[k][0]);
            n_checks++; if (fill !== 3'(m_q.size())) $display("FAIL rnd_fill: got %0d expected %0d", fill, m_q.size()); else n_pass++;
            n_checks++; if (data_av !== (m_q.size() > 0)) $display("FAIL rnd_av: got %0b expected %0b", data_av, m_q.size() > 0); else n_pass++;
            n_checks++; if (overrun !== m_ovr) $display("FAIL rnd_overrun: got %0b expected %0b", overrun, m_ovr); else n_pass++;
            n_checks++; if (frame_err !== m_ferr) $display("FAIL rnd_frame_err: got %0b expected %0b", frame_err, m_ferr); else n_pass++;
            if (m_q.size() > 0) begin
                n_checks++; if (data_out !== m_q[0]) $display("FAIL rnd_data: got %0h expected %0h", data_out, m_q[0]); else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_overrun();
        test_full_push_pop();
        test_frame_err();
        test_exact_frame();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
